// File: rtl/icache_pkg.sv
// Shared types for the instruction cache: frame layout, FSM encoding and
// the saturating increment used by the performance counters.
package icache_pkg;

  localparam int WORD_W    = 32;
  localparam int TAG_MAX_W = 30;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } icache_state_e;

  // Tags narrower than TAG_MAX_W are stored zero-extended.
  typedef struct packed {
    logic                 valid;
    logic [TAG_MAX_W-1:0] tag;
    logic [WORD_W-1:0]    data;
  } icache_frame_t;

  function automatic logic [WORD_W-1:0] sat_inc(input logic [WORD_W-1:0] v);
    return (v == {WORD_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/icache.sv
// Direct-mapped, read-only instruction cache with zero-latency hits,
// a single outstanding fill and a same-cycle bypass of the returning word.
module icache
  import icache_pkg::*;
#(
  parameter int SETS = 16,
  parameter int BLKW = 1
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);

  localparam int OFF_W = 2 + $clog2(BLKW);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 32 - OFF_W - IDX_W;

  icache_state_e        r_state;
  logic [31:0]          r_miss_addr;
  logic [31:0]          r_hit_count;
  logic [31:0]          r_miss_count;
  icache_frame_t        r_frames [SETS];

  logic [IDX_W-1:0]     w_idx;
  logic [TAG_MAX_W-1:0] w_tag;
  logic [IDX_W-1:0]     w_miss_idx;
  logic [TAG_MAX_W-1:0] w_miss_tag;
  logic [31:0]          w_req_addr;
  icache_frame_t        w_frame;
  logic                 w_hit;
  logic                 w_bypass;
  logic                 w_unused;

  assign w_idx      = imemaddr[OFF_W +: IDX_W];
  assign w_tag      = {{(TAG_MAX_W-TAG_W){1'b0}}, imemaddr[31 -: TAG_W]};
  assign w_miss_idx = r_miss_addr[OFF_W +: IDX_W];
  assign w_miss_tag = {{(TAG_MAX_W-TAG_W){1'b0}}, r_miss_addr[31 -: TAG_W]};
  assign w_req_addr = {imemaddr[31:2], 2'b00};
  assign w_frame    = r_frames[w_idx];
  assign w_unused   = ^{imemaddr[1:0], r_miss_addr[1:0]};

  assign w_hit    = (r_state == IDLE) && imemREN && w_frame.valid && (w_frame.tag == w_tag);
  // Returning word is forwarded only if the datapath still wants that address.
  assign w_bypass = (r_state == FILL) && !iwait && imemREN && (w_req_addr == r_miss_addr);

  always_comb begin
    ihit     = w_hit || w_bypass;
    imemload = 32'd0;
    if (w_hit)
      imemload = w_frame.data;
    else if (w_bypass)
      imemload = iload;
    iREN  = (r_state == FILL);
    iaddr = (r_state == FILL) ? r_miss_addr : 32'd0;
  end

  assign hit_count  = r_hit_count;
  assign miss_count = r_miss_count;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state      <= IDLE;
      r_miss_addr  <= 32'd0;
      r_hit_count  <= 32'd0;
      r_miss_count <= 32'd0;
      for (int i = 0; i < SETS; i++)
        r_frames[i] <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_hit) begin
            r_hit_count <= sat_inc(r_hit_count);
          end else if (imemREN) begin
            r_miss_addr  <= w_req_addr;
            r_miss_count <= sat_inc(r_miss_count);
            r_state      <= FILL;
          end
        end
        FILL: begin
          // Fill always lands, even if the datapath was redirected meanwhile.
          if (!iwait) begin
            r_frames[w_miss_idx] <= '{valid: 1'b1, tag: w_miss_tag, data: iload};
            r_state              <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_icache.sv
// Bench for icache: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a behavioural cache model.
module tb_icache;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  icache #(.SETS(16), .BLKW(1)) dut (
    .CLK       (CLK),
    .nRST      (nRST),
    .imemREN   (imemREN),
    .imemaddr  (imemaddr),
    .ihit      (ihit),
    .imemload  (imemload),
    .iREN      (iREN),
    .iaddr     (iaddr),
    .iwait     (iwait),
    .iload     (iload),
    .hit_count (hit_count),
    .miss_count(miss_count)
  );

  always #5 CLK = ~CLK;

  int n_chk  = 0;
  int n_pass = 0;

  // Model: which word address each set currently holds, plus one pending miss.
  bit          m_valid [16];
  logic [29:0] m_word  [16];
  logic [31:0] m_data  [16];
  bit          m_fill;
  logic [31:0] m_maddr;
  logic [31:0] m_hits;
  logic [31:0] m_misses;

  logic        obs_ihit, obs_iren;
  logic [31:0] obs_load, obs_iaddr;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  function automatic logic [31:0] sat(input logic [31:0] v);
    return (v == 32'hFFFFFFFF) ? v : v + 32'd1;
  endfunction

  function automatic logic [31:0] memword(input logic [31:0] a);
    return (a * 32'h9E3779B9) ^ 32'h5A5A1234;
  endfunction

  function automatic int set_of(input logic [31:0] a);
    return int'((a >> 2) % 16);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 1'b0;
      m_word[i]  = '0;
      m_data[i]  = '0;
    end
    m_fill   = 1'b0;
    m_maddr  = '0;
    m_hits   = '0;
    m_misses = '0;
  endtask

  // Called just after a falling edge with inputs already driven.
  task automatic cycle();
    logic        e_hit, e_ren;
    logic [31:0] e_load, e_addr, waddr;
    int          s;
    #2;
    waddr = {imemaddr[31:2], 2'b00};
    s     = set_of(waddr);
    if (!m_fill) begin
      e_hit  = imemREN && m_valid[s] && (m_word[s] == waddr[31:2]);
      e_load = e_hit ? m_data[s] : 32'd0;
      e_ren  = 1'b0;
      e_addr = 32'd0;
    end else begin
      e_hit  = !iwait && imemREN && (waddr == m_maddr);
      e_load = e_hit ? iload : 32'd0;
      e_ren  = 1'b1;
      e_addr = m_maddr;
    end
    obs_ihit  = ihit;
    obs_load  = imemload;
    obs_iren  = iREN;
    obs_iaddr = iaddr;
    chk("ihit",     {31'd0, ihit}, {31'd0, e_hit});
    chk("imemload", imemload, e_load);
    chk("iREN",     {31'd0, iREN}, {31'd0, e_ren});
    chk("iaddr",    iaddr, e_addr);
    @(posedge CLK);
    if (!m_fill) begin
      if (e_hit) m_hits = sat(m_hits);
      else if (imemREN) begin
        m_fill   = 1'b1;
        m_maddr  = waddr;
        m_misses = sat(m_misses);
      end
    end else if (!iwait) begin
      s          = set_of(m_maddr);
      m_valid[s] = 1'b1;
      m_word[s]  = m_maddr[31:2];
      m_data[s]  = iload;
      m_fill     = 1'b0;
    end
    #1;
    chk("hit_count",  hit_count,  m_hits);
    chk("miss_count", miss_count, m_misses);
    @(negedge CLK);
  endtask

  task automatic drive(input logic ren, input logic [31:0] a, input logic w, input logic [31:0] ld);
    imemREN  = ren;
    imemaddr = a;
    iwait    = w;
    iload    = ld;
  endtask

  int iren_cycles;

  initial begin
    nRST = 1'b0;
    drive(1'b0, 32'd0, 1'b1, 32'd0);
    model_reset();
    #3;
    chk("rst_ihit",     {31'd0, ihit}, 32'd0);
    chk("rst_imemload", imemload, 32'd0);
    chk("rst_iREN",     {31'd0, iREN}, 32'd0);
    chk("rst_iaddr",    iaddr, 32'd0);
    chk("rst_hits",     hit_count, 32'd0);
    chk("rst_misses",   miss_count, 32'd0);
    @(negedge CLK);
    @(negedge CLK);
    nRST = 1'b1;
    @(negedge CLK);

    // First fetch of 0x0: three stalled cycles then data returns.
    iren_cycles = 0;
    drive(1'b1, 32'h0, 1'b1, 32'hDEADBEEF);
    cycle();
    chk("req0_ihit", {31'd0, obs_ihit}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      cycle();
      if (obs_iren) iren_cycles++;
    end
    drive(1'b1, 32'h0, 1'b0, 32'h2008000A);
    cycle();
    if (obs_iren) iren_cycles++;
    chk("fill_iren_cycles", iren_cycles, 32'd4);
    chk("fill_bypass_ihit", {31'd0, obs_ihit}, 32'd1);
    chk("fill_bypass_data", obs_load, 32'h2008000A);
    chk("fill_miss_count",  miss_count, 32'd1);

    drive(1'b1, 32'h0, 1'b1, 32'h0);
    cycle();
    chk("rehit_ihit", {31'd0, obs_ihit}, 32'd1);
    chk("rehit_data", obs_load, 32'h2008000A);
    chk("rehit_iren", {31'd0, obs_iren}, 32'd0);
    chk("rehit_hits", hit_count, 32'd1);

    // 0x40 shares set 0 with 0x0 and evicts it.
    drive(1'b1, 32'h40, 1'b0, memword(32'h40));
    cycle();
    cycle();
    drive(1'b1, 32'h0, 1'b0, memword(32'h0));
    cycle();
    chk("evict_ihit",   {31'd0, obs_ihit}, 32'd0);
    chk("evict_misses", miss_count, 32'd3);
    cycle();

    // Redirect while filling 0x4.
    drive(1'b1, 32'h4, 1'b1, 32'h0);
    cycle();
    drive(1'b1, 32'h100, 1'b1, 32'h0);
    cycle();
    chk("redir_iaddr", obs_iaddr, 32'h4);
    drive(1'b1, 32'h100, 1'b0, 32'h11112222);
    cycle();
    chk("redir_ihit",  {31'd0, obs_ihit}, 32'd0);
    chk("redir_iaddr2", obs_iaddr, 32'h4);
    drive(1'b1, 32'h4, 1'b1, 32'h0);
    cycle();
    chk("redir_later_hit",  {31'd0, obs_ihit}, 32'd1);
    chk("redir_later_data", obs_load, 32'h11112222);

    // Reset in the middle of a fill of 0x8.
    drive(1'b1, 32'h8, 1'b1, 32'h0);
    cycle();
    cycle();
    nRST = 1'b0;
    #1;
    model_reset();
    chk("midrst_iren",   {31'd0, iREN}, 32'd0);
    chk("midrst_iaddr",  iaddr, 32'd0);
    chk("midrst_misses", miss_count, 32'd0);
    @(negedge CLK);
    nRST = 1'b1;
    drive(1'b1, 32'h4, 1'b0, 32'h33334444);
    cycle();
    chk("postrst_miss", {31'd0, obs_ihit}, 32'd0);
    cycle();

    // Hit counter saturation.
    force dut.r_hit_count = 32'hFFFFFFFE;
    #1;
    release dut.r_hit_count;
    m_hits = 32'hFFFFFFFE;
    drive(1'b1, 32'h4, 1'b1, 32'h0);
    cycle();
    cycle();
    chk("sat_hits", hit_count, 32'hFFFFFFFF);

    // Randomized traffic over 4 tags x 16 sets.
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] a;
      logic        w;
      a = ({28'd0, 4'($urandom_range(0, 3))} << 6) | ({28'd0, 4'($urandom_range(0, 15))} << 2)
          | {30'd0, 2'($urandom_range(0, 3))};
      if (m_fill && ($urandom_range(0, 3) != 0)) a = m_maddr;
      w = ($urandom_range(0, 1) == 1);
      drive(($urandom_range(0, 4) != 0), a, w,
            (m_fill && !w) ? memword(m_maddr) : $urandom);
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
